// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared types and helpers for the PCM downlink frame generator
package pcm_pkg;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_START = 2'd1,
        PC_SYNC  = 2'd2,
        PC_END   = 2'd3
    } period_class_t;

    localparam int OVF_W = 8;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic period_class_t classify(input int period, input int word_bits);
        if (period == 0) return PC_START;
        if (period <= word_bits) return PC_SYNC;
        if (period == word_bits + 1) return PC_END;
        return PC_IDLE;
    endfunction

endpackage

// File: rtl/pcm_word_fifo.sv
// rtl/pcm_word_fifo.sv - first-word-fall-through word FIFO; a pop frees room for a same-cycle push when full
module pcm_word_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_tdata,
    input  logic             wr_tvalid,
    output logic [WIDTH-1:0] rd_tdata,
    output logic             rd_tvalid,
    input  logic             rd_tready,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             pop;
    logic             do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rd_tready && !empty;
    assign do_push  = wr_tvalid && (!full || pop);
    assign rd_tvalid = !empty;
    assign rd_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_tdata;
    end

endmodule

// File: rtl/pcm_downlink_frame.sv
// rtl/pcm_downlink_frame.sv - DKSTRT/DKBSNC/DKEND sync train, DKDATA word assembly and word FIFO
module pcm_downlink_frame
    import pcm_pkg::*;
#(
    parameter int SLOTS_PER_BIT = 20,
    parameter int PULSE_LEN     = 4,
    parameter int SAMPLE_SLOT   = 2,
    parameter int WORD_BITS     = 40,
    parameter int FRAME_BITS    = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 agc_clk_in,
    input  logic                 dkdata,
    output logic                 dkstrt,
    output logic                 dkbsnc,
    output logic                 dkend,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [OVF_W-1:0]     overflow_cnt,
    output logic                 frame_active
);
    localparam int SLOT_W = cnt_width(SLOTS_PER_BIT);
    localparam int PER_W  = cnt_width(FRAME_BITS);

    logic                 sync1, sync2, sync_hist;
    logic                 edge_evt;
    logic [SLOT_W-1:0]    slot, slot_nxt;
    logic [PER_W-1:0]     period, period_nxt;
    period_class_t        nxt_cls;
    logic                 in_pulse;
    logic                 at_sample;
    logic                 run_evt;
    logic                 push;
    logic                 fifo_full;
    logic                 pop;
    logic [WORD_BITS-1:0] shreg;

    // Synchroniser runs freely; reset/enable only act on the counters behind it.
    always_ff @(posedge clk) begin
        sync1     <= agc_clk_in;
        sync2     <= sync1;
        sync_hist <= sync2;
    end

    assign edge_evt = sync2 && !sync_hist;
    assign run_evt  = enable && edge_evt;

    always_comb begin
        slot_nxt   = slot + 1'b1;
        period_nxt = period;
        if (slot == SLOT_W'(SLOTS_PER_BIT - 1)) begin
            slot_nxt   = '0;
            period_nxt = (period == PER_W'(FRAME_BITS - 1)) ? '0 : period + 1'b1;
        end
    end

    assign nxt_cls   = classify(int'(period_nxt), WORD_BITS);
    assign in_pulse  = (slot_nxt < SLOT_W'(PULSE_LEN));
    assign at_sample = (slot_nxt == SLOT_W'(SAMPLE_SLOT));
    assign push      = run_evt && (nxt_cls == PC_END) && at_sample;

    // Everything below is decoded from the post-update counters so pulses trail E by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            slot         <= '0;
            period       <= PER_W'(FRAME_BITS - 1);
            shreg        <= '0;
            dkstrt       <= 1'b0;
            dkbsnc       <= 1'b0;
            dkend        <= 1'b0;
            frame_active <= 1'b0;
        end else if (edge_evt) begin
            slot         <= slot_nxt;
            period       <= period_nxt;
            dkstrt       <= (nxt_cls == PC_START) && in_pulse;
            dkbsnc       <= (nxt_cls == PC_SYNC) && in_pulse;
            dkend        <= (nxt_cls == PC_END) && in_pulse;
            frame_active <= (nxt_cls != PC_IDLE);
            if ((nxt_cls == PC_SYNC) && at_sample) begin
                shreg <= WORD_BITS'({shreg, dkdata});
            end else if (push) begin
                shreg <= '0;
            end
        end
    end

    assign pop = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (push && fifo_full && !pop && (overflow_cnt != {OVF_W{1'b1}})) begin
            overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    pcm_word_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_tdata  (shreg),
        .wr_tvalid (push),
        .rd_tdata  (word_data),
        .rd_tvalid (word_valid),
        .rd_tready (word_ready),
        .full      (fifo_full)
    );

endmodule
